// File: rtl/rv32i_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rv32i_pkg
// Description : Shared RV32I memory-stage types: memory op encoding, FSM
//               states, funct3 load/store codes and an access-size helper.
// Revision    : 1.0 - initial release
// ============================================================================
package rv32i_pkg;

  // Memory operation carried down from execute
  typedef enum logic [1:0] {
    MEM_NONE  = 2'd0,
    MEM_LOAD  = 2'd1,
    MEM_STORE = 2'd2
  } mem_op_t;

  // Memory-stage FSM states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } mem_state_t;

  // Access size decoded from funct3
  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } acc_size_t;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  // Undefined encodings (011, 110, 111) fall through to a full-word access
  function automatic acc_size_t f3_size(input logic [2:0] f3);
    case (f3)
      F3_LB, F3_LBU: f3_size = SZ_BYTE;
      F3_LH, F3_LHU: f3_size = SZ_HALF;
      default:       f3_size = SZ_WORD;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_align.sv
`default_nettype none
// ============================================================================
// Module      : lsu_align
// Description : Combinational lane steering for RV32I loads/stores. Produces
//               byte enables, lane-replicated store data and the aligned,
//               sign/zero-extended load value.
// Revision    : 1.0 - initial release
// ============================================================================
module lsu_align
  import rv32i_pkg::*;
(
  input  logic [2:0]  i_funct3,
  input  logic [1:0]  i_addr_lo,
  input  logic [31:0] i_store_data,
  input  logic [31:0] i_rdata,
  output logic [3:0]  o_be,
  output logic [31:0] o_wdata,
  output logic [31:0] o_load_val
);

  acc_size_t   w_size;
  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Select the addressed lane and build enables/store data for the access size
  always_comb begin
    w_size = f3_size(i_funct3);

    case (i_addr_lo)
      2'd0:    w_byte = i_rdata[7:0];
      2'd1:    w_byte = i_rdata[15:8];
      2'd2:    w_byte = i_rdata[23:16];
      default: w_byte = i_rdata[31:24];
    endcase
    w_half = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];

    case (w_size)
      SZ_BYTE: begin
        o_be       = 4'b0001 << i_addr_lo;
        o_wdata    = {4{i_store_data[7:0]}};
        // funct3[2] distinguishes the unsigned variants LBU/LHU
        o_load_val = i_funct3[2] ? {24'd0, w_byte} : {{24{w_byte[7]}}, w_byte};
      end
      SZ_HALF: begin
        o_be       = 4'b0011 << {i_addr_lo[1], 1'b0};
        o_wdata    = {2{i_store_data[15:0]}};
        o_load_val = i_funct3[2] ? {16'd0, w_half} : {{16{w_half[15]}}, w_half};
      end
      default: begin
        o_be       = 4'b1111;
        o_wdata    = i_store_data;
        o_load_val = i_rdata;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/mem_access.sv
`default_nettype none
// ============================================================================
// Module      : mem_access
// Description : RV32I memory stage. Issues LB/LH/LW/LBU/LHU/SB/SH/SW on a
//               req/ack data-memory port, aligns load data, forwards the
//               write-back value and rd, and stalls upstream while busy.
//               Optional macro MEM_MISALIGN_TRAP_EN: misaligned half/word
//               accesses trap with misalign_fault instead of being aligned
//               down by forcing the low address bits to zero.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_access
  import rv32i_pkg::*;
#(
  parameter int ACK_TIMEOUT = 64,
  parameter int CNT_W       = 7
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_mem_ctl_in,
  input  logic [31:0] i_alu_result,
  input  logic [31:0] i_store_data,
  input  logic [1:0]  i_mem_op,
  input  logic [2:0]  i_funct3,
  input  logic [4:0]  i_rd_src,
  output logic        o_stall,
  output logic        o_dmem_req,
  output logic        o_dmem_we,
  output logic [31:0] o_dmem_addr,
  output logic [3:0]  o_dmem_be,
  output logic [31:0] o_dmem_wdata,
  input  logic [31:0] i_dmem_rdata,
  input  logic        i_dmem_ack,
  output logic        o_mem_ctl_out,
  output logic [31:0] o_wb_data,
  output logic        o_wb_en,
  output logic [4:0]  o_rd_dst,
  output logic        o_bus_fault,
  output logic        o_misalign_fault
);

  mem_state_t       r_state;
  mem_state_t       w_next;
  logic [CNT_W-1:0] r_cnt;
  logic [31:0]      r_addr;     // address, or the result itself for MEM_NONE
  logic [31:0]      r_sdata;
  logic [31:0]      r_rdata;
  logic [2:0]       r_f3;
  logic [4:0]       r_rd;
  logic             r_we;
  logic             r_none_vld;
  logic             r_bus_flt;
  logic             r_mis_flt;

  logic             w_accept;
  logic             w_is_mem;
  logic             w_mis;
  logic             w_timeout;
  logic [31:0]      w_eff_addr;
  logic [3:0]       w_be;
  logic [31:0]      w_wdata;
  logic [31:0]      w_load_val;

  // Upstream pulses are honoured only in IDLE; anything else is a protocol error
  assign w_accept  = i_mem_ctl_in && (r_state == IDLE);
  assign w_is_mem  = (i_mem_op == MEM_LOAD) || (i_mem_op == MEM_STORE);
  assign w_timeout = (r_cnt == CNT_W'(ACK_TIMEOUT - 1)) && !i_dmem_ack;

`ifdef MEM_MISALIGN_TRAP_EN
  acc_size_t w_in_size;
  assign w_in_size = f3_size(i_funct3);
  assign w_mis = ((w_in_size == SZ_HALF) && i_alu_result[0]) ||
                 ((w_in_size == SZ_WORD) && (i_alu_result[1:0] != 2'b00));
`else
  assign w_mis = 1'b0;
`endif

  // Clear address bits below the access size so lane selection stays in range
  always_comb begin
    w_eff_addr = r_addr;
    case (f3_size(r_f3))
      SZ_HALF: w_eff_addr[0]   = 1'b0;
      SZ_WORD: w_eff_addr[1:0] = 2'b00;
      default: ;
    endcase
  end

  lsu_align u_lsu_align (
    .i_funct3     (r_f3),
    .i_addr_lo    (w_eff_addr[1:0]),
    .i_store_data (r_sdata),
    .i_rdata      (r_rdata),
    .o_be         (w_be),
    .o_wdata      (w_wdata),
    .o_load_val   (w_load_val)
  );

  // State register; async reset drops the request immediately
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_next;
  end

  // Next-state: faults reuse RESP so the fault pulse is covered by stall
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_accept && w_is_mem) w_next = w_mis ? RESP : REQ;
      REQ:     if (i_dmem_ack || w_timeout) w_next = RESP;
      RESP:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Latch the transaction, count wait cycles and capture the ack data
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt      <= '0;
      r_addr     <= '0;
      r_sdata    <= '0;
      r_rdata    <= '0;
      r_f3       <= '0;
      r_rd       <= '0;
      r_we       <= 1'b0;
      r_none_vld <= 1'b0;
      r_bus_flt  <= 1'b0;
      r_mis_flt  <= 1'b0;
    end else begin
      r_none_vld <= w_accept && !w_is_mem;
      if (w_accept) begin
        r_addr    <= i_alu_result;
        r_sdata   <= i_store_data;
        r_f3      <= i_funct3;
        r_rd      <= i_rd_src;
        r_we      <= (i_mem_op == MEM_STORE);
        r_cnt     <= '0;
        r_bus_flt <= 1'b0;
        r_mis_flt <= w_is_mem && w_mis;
      end
      if (r_state == REQ) begin
        r_cnt     <= r_cnt + 1'b1;
        r_bus_flt <= w_timeout;
        if (i_dmem_ack) r_rdata <= i_dmem_rdata;
      end
    end
  end

  // Outputs decoded from state; bus fields are zero outside REQ
  always_comb begin
    o_stall          = (r_state != IDLE);
    o_dmem_req       = 1'b0;
    o_dmem_we        = 1'b0;
    o_dmem_addr      = '0;
    o_dmem_be        = '0;
    o_dmem_wdata     = '0;
    o_mem_ctl_out    = 1'b0;
    o_wb_data        = '0;
    o_wb_en          = 1'b0;
    o_rd_dst         = '0;
    o_bus_fault      = 1'b0;
    o_misalign_fault = 1'b0;
    case (r_state)
      REQ: begin
        o_dmem_req   = 1'b1;
        o_dmem_we    = r_we;
        o_dmem_addr  = {w_eff_addr[31:2], 2'b00};
        o_dmem_be    = w_be;
        o_dmem_wdata = w_wdata;
      end
      RESP: begin
        o_mem_ctl_out    = 1'b1;
        o_rd_dst         = r_rd;
        o_bus_fault      = r_bus_flt;
        o_misalign_fault = r_mis_flt;
        if (!r_bus_flt && !r_mis_flt && !r_we) begin
          o_wb_data = w_load_val;
          o_wb_en   = (r_rd != 5'd0);
        end
      end
      default: begin
        if (r_none_vld) begin
          o_mem_ctl_out = 1'b1;
          o_wb_data     = r_addr;
          o_wb_en       = (r_rd != 5'd0);
          o_rd_dst      = r_rd;
        end
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_access.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_access
// Description : Directed, table-driven bench for mem_access with hand-written
//               sequences for timeout, protocol error, misalignment and reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_access;
  import rv32i_pkg::*;

  logic        clk;
  logic        rst;
  logic        mem_ctl_in;
  logic [31:0] alu_result;
  logic [31:0] store_data;
  logic [1:0]  mem_op;
  logic [2:0]  funct3;
  logic [4:0]  rd_src;
  logic        stall;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata;
  logic        dmem_ack;
  logic        mem_ctl_out;
  logic [31:0] wb_data;
  logic        wb_en;
  logic [4:0]  rd_dst;
  logic        bus_fault;
  logic        misalign_fault;

  int checks = 0;
  int errors = 0;

  mem_access #(.ACK_TIMEOUT(64), .CNT_W(7)) dut (
    .clk              (clk),
    .rst              (rst),
    .i_mem_ctl_in     (mem_ctl_in),
    .i_alu_result     (alu_result),
    .i_store_data     (store_data),
    .i_mem_op         (mem_op),
    .i_funct3         (funct3),
    .i_rd_src         (rd_src),
    .o_stall          (stall),
    .o_dmem_req       (dmem_req),
    .o_dmem_we        (dmem_we),
    .o_dmem_addr      (dmem_addr),
    .o_dmem_be        (dmem_be),
    .o_dmem_wdata     (dmem_wdata),
    .i_dmem_rdata     (dmem_rdata),
    .i_dmem_ack       (dmem_ack),
    .o_mem_ctl_out    (mem_ctl_out),
    .o_wb_data        (wb_data),
    .o_wb_en          (wb_en),
    .o_rd_dst         (rd_dst),
    .o_bus_fault      (bus_fault),
    .o_misalign_fault (misalign_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] sdata;
    logic [31:0] rdata;
    int          dly;      // REQ cycles before the one carrying ack
    logic [4:0]  rd;
    logic [31:0] e_addr;
    logic [3:0]  e_be;
    logic [31:0] e_wdata;
    logic        e_we;
    logic [31:0] e_wb;
    logic        e_wben;
    logic        chk_wb;
    int          e_stall;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic [1:0] op, input logic [2:0] f3,
                              input logic [31:0] addr, input logic [31:0] sdata,
                              input logic [31:0] rdata, input int dly, input logic [4:0] rd,
                              input logic [31:0] e_addr, input logic [3:0] e_be,
                              input logic [31:0] e_wdata, input logic e_we,
                              input logic [31:0] e_wb, input logic e_wben,
                              input logic chk_wb, input int e_stall);
    vec_t v;
    v.op = op; v.f3 = f3; v.addr = addr; v.sdata = sdata; v.rdata = rdata;
    v.dly = dly; v.rd = rd; v.e_addr = e_addr; v.e_be = e_be; v.e_wdata = e_wdata;
    v.e_we = e_we; v.e_wb = e_wb; v.e_wben = e_wben; v.chk_wb = chk_wb; v.e_stall = e_stall;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Issue one transaction, serve it with the table's ack delay, compare results
  task automatic run_vec(input vec_t v, input int idx);
    int          req_n, stall_n, cyc;
    bit          seen_req, done;
    logic [31:0] a_addr, a_wdata, a_wb;
    logic [3:0]  a_be;
    logic        a_we, a_wben;
    logic [4:0]  a_rd;
    string       tag;
    tag = $sformatf("v%0d", idx);
    a_addr = '0; a_wdata = '0; a_wb = '0; a_be = '0; a_we = 1'b0; a_wben = 1'b0; a_rd = '0;
    mem_ctl_in = 1'b1; mem_op = v.op; funct3 = v.f3; alu_result = v.addr;
    store_data = v.sdata; rd_src = v.rd;
    tick();
    mem_ctl_in = 1'b0;
    req_n = 0; stall_n = 0; seen_req = 1'b0; done = 1'b0;
    for (cyc = 0; cyc < 200 && !done; cyc++) begin
      dmem_ack = 1'b0;
      if (stall) stall_n++;
      if (dmem_req) begin
        if (!seen_req) begin
          a_addr = dmem_addr; a_be = dmem_be; a_wdata = dmem_wdata; a_we = dmem_we;
        end
        seen_req = 1'b1;
        if (req_n == v.dly) begin
          dmem_ack = 1'b1; dmem_rdata = v.rdata;
        end
        req_n++;
      end
      if (mem_ctl_out) begin
        a_wb = wb_data; a_wben = wb_en; a_rd = rd_dst; done = 1'b1;
      end
      if (!done) tick();
    end
    dmem_ack = 1'b0;
    chk({tag, " completed"}, {31'd0, done}, 32'd1);
    chk({tag, " stall_cycles"}, stall_n, v.e_stall);
    chk({tag, " wb_en"}, {31'd0, a_wben}, {31'd0, v.e_wben});
    chk({tag, " rd_dst"}, {27'd0, a_rd}, {27'd0, v.rd});
    if (v.chk_wb) chk({tag, " wb_data"}, a_wb, v.e_wb);
    if (v.op == 2'd0) begin
      chk({tag, " no_req"}, {31'd0, seen_req}, 32'd0);
    end else begin
      chk({tag, " req_seen"}, {31'd0, seen_req}, 32'd1);
      chk({tag, " dmem_addr"}, a_addr, v.e_addr);
      chk({tag, " dmem_be"}, {28'd0, a_be}, {28'd0, v.e_be});
      chk({tag, " dmem_wdata"}, a_wdata, v.e_wdata);
      chk({tag, " dmem_we"}, {31'd0, a_we}, {31'd0, v.e_we});
    end
    tick();
  endtask

  initial begin
    int n;
    rst = 1'b0; mem_ctl_in = 1'b0; alu_result = '0; store_data = '0; mem_op = '0;
    funct3 = '0; rd_src = '0; dmem_rdata = '0; dmem_ack = 1'b0;

    //        op    f3      addr          sdata         rdata         dly rd    e_addr        e_be     e_wdata       we    e_wb          wben chk stall
    vecs.push_back(mk(2'd0, 3'b000, 32'h0000_1234, 32'h0,        32'h0,        0, 5'd5, 32'h0,        4'b0000, 32'h0,        1'b0, 32'h0000_1234, 1'b1, 1'b1, 0));
    vecs.push_back(mk(2'd0, 3'b000, 32'h0000_ABCD, 32'h0,        32'h0,        0, 5'd0, 32'h0,        4'b0000, 32'h0,        1'b0, 32'h0000_ABCD, 1'b0, 1'b1, 0));
    vecs.push_back(mk(2'd1, F3_LB,  32'h0000_1003, 32'h0,        32'h80AA_BBCC, 3, 5'd7, 32'h0000_1000, 4'b1000, 32'h0,        1'b0, 32'hFFFF_FF80, 1'b1, 1'b1, 5));
    vecs.push_back(mk(2'd2, F3_SH,  32'h0000_2002, 32'hDEAD_BEEF, 32'h0,       0, 5'd0, 32'h0000_2000, 4'b1100, 32'hBEEF_BEEF, 1'b1, 32'h0,        1'b0, 1'b0, 2));
    vecs.push_back(mk(2'd1, F3_LBU, 32'h0000_1001, 32'h0,        32'h80AA_BBCC, 1, 5'd3, 32'h0000_1000, 4'b0010, 32'h0,        1'b0, 32'h0000_00BB, 1'b1, 1'b1, 3));
    vecs.push_back(mk(2'd1, F3_LH,  32'h0000_1002, 32'h0,        32'h80AA_BBCC, 0, 5'd4, 32'h0000_1000, 4'b1100, 32'h0,        1'b0, 32'hFFFF_80AA, 1'b1, 1'b1, 2));
    vecs.push_back(mk(2'd1, F3_LW,  32'h0000_1004, 32'h0,        32'h1234_5678, 2, 5'd0, 32'h0000_1004, 4'b1111, 32'h0,        1'b0, 32'h0,        1'b0, 1'b0, 4));
    vecs.push_back(mk(2'd2, F3_SB,  32'h0000_3001, 32'h0000_00A5, 32'h0,       1, 5'd0, 32'h0000_3000, 4'b0010, 32'hA5A5_A5A5, 1'b1, 32'h0,        1'b0, 1'b0, 3));
    vecs.push_back(mk(2'd2, F3_SW,  32'h0000_3008, 32'hCAFE_BABE, 32'h0,       0, 5'd0, 32'h0000_3008, 4'b1111, 32'hCAFE_BABE, 1'b1, 32'h0,        1'b0, 1'b0, 2));
    vecs.push_back(mk(2'd1, 3'b011, 32'h0000_100C, 32'h0,        32'hF00D_F00D, 0, 5'd9, 32'h0000_100C, 4'b1111, 32'h0,        1'b0, 32'hF00D_F00D, 1'b1, 1'b1, 2));
    vecs.push_back(mk(2'd1, F3_LHU, 32'h0000_2000, 32'h0,        32'h1234_8765, 1, 5'd11, 32'h0000_2000, 4'b0011, 32'h0,       1'b0, 32'h0000_8765, 1'b1, 1'b1, 3));
`ifndef MEM_MISALIGN_TRAP_EN
    vecs.push_back(mk(2'd1, F3_LW,  32'h0000_3001, 32'h0,        32'h5566_7788, 1, 5'd12, 32'h0000_3000, 4'b1111, 32'h0,       1'b0, 32'h5566_7788, 1'b1, 1'b1, 3));
    vecs.push_back(mk(2'd2, F3_SH,  32'h0000_2003, 32'h0000_BEEF, 32'h0,       0, 5'd0, 32'h0000_2000, 4'b1100, 32'hBEEF_BEEF, 1'b1, 32'h0,        1'b0, 1'b0, 2));
`endif

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    chk("rst stall", {31'd0, stall}, 32'd0);
    chk("rst dmem_req", {31'd0, dmem_req}, 32'd0);
    chk("rst mem_ctl_out", {31'd0, mem_ctl_out}, 32'd0);
    chk("rst outs", {dmem_addr | dmem_wdata | wb_data}, 32'd0);
    chk("rst bits", {22'd0, dmem_be, dmem_we, wb_en, rd_dst}, 32'd0);
    rst = 1'b1;
    tick();

    foreach (vecs[i]) run_vec(vecs[i], i);

    // Ack timeout: req held 64 cycles, then fault pulse with no write-back
    mem_ctl_in = 1'b1; mem_op = 2'd1; funct3 = F3_LW; alu_result = 32'h0000_5000; rd_src = 5'd6;
    tick();
    mem_ctl_in = 1'b0;
    n = 0;
    for (int i = 0; i < 200 && dmem_req; i++) begin
      n++;
      tick();
    end
    chk("timeout req_cycles", n, 64);
    chk("timeout bus_fault", {31'd0, bus_fault}, 32'd1);
    chk("timeout mem_ctl_out", {31'd0, mem_ctl_out}, 32'd1);
    chk("timeout wb_en", {31'd0, wb_en}, 32'd0);
    chk("timeout stall", {31'd0, stall}, 32'd1);
    tick();
    chk("timeout idle stall", {31'd0, stall}, 32'd0);
    chk("timeout pulse_len", {30'd0, bus_fault, mem_ctl_out}, 32'd0);

    // Protocol error: a pulse while stalled is ignored
    mem_ctl_in = 1'b1; mem_op = 2'd1; funct3 = F3_LBU; alu_result = 32'h0000_1000; rd_src = 5'd2;
    tick();
    mem_ctl_in = 1'b1; mem_op = 2'd0; alu_result = 32'h0000_0999; rd_src = 5'd17;
    dmem_ack = 1'b1; dmem_rdata = 32'h1122_337F;
    tick();
    mem_ctl_in = 1'b0; dmem_ack = 1'b0;
    chk("perr mem_ctl_out", {31'd0, mem_ctl_out}, 32'd1);
    chk("perr wb_data", wb_data, 32'h0000_007F);
    chk("perr rd_dst", {27'd0, rd_dst}, 32'd2);
    tick();
    chk("perr no_extra_pulse", {31'd0, mem_ctl_out}, 32'd0);
    tick();

`ifdef MEM_MISALIGN_TRAP_EN
    // Misaligned word load traps without touching the bus
    mem_ctl_in = 1'b1; mem_op = 2'd1; funct3 = F3_LW; alu_result = 32'h0000_3001; rd_src = 5'd8;
    tick();
    mem_ctl_in = 1'b0;
    chk("mis misalign_fault", {31'd0, misalign_fault}, 32'd1);
    chk("mis mem_ctl_out", {31'd0, mem_ctl_out}, 32'd1);
    chk("mis wb_en", {31'd0, wb_en}, 32'd0);
    chk("mis dmem_req", {31'd0, dmem_req}, 32'd0);
    tick();
    chk("mis idle", {29'd0, misalign_fault, dmem_req, stall}, 32'd0);
`endif

    // Reset in REQ drops outputs without waiting for a clock
    mem_ctl_in = 1'b1; mem_op = 2'd1; funct3 = F3_LW; alu_result = 32'h0000_6000; rd_src = 5'd1;
    tick();
    mem_ctl_in = 1'b0;
    chk("rstmid req_before", {31'd0, dmem_req}, 32'd1);
    #2;
    rst = 1'b0;
    #1;
    chk("rstmid dmem_req", {31'd0, dmem_req}, 32'd0);
    chk("rstmid stall", {31'd0, stall}, 32'd0);
    chk("rstmid mem_ctl_out", {31'd0, mem_ctl_out}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    tick();
    run_vec(mk(2'd1, F3_LHU, 32'h0000_4002, 32'h0, 32'hCAFE_1234, 0, 5'd10, 32'h0000_4000,
               4'b1100, 32'h0, 1'b0, 32'h0000_CAFE, 1'b1, 1'b1, 2), 99);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
